// File: rtl/tdma_pkg.sv
// rtl/tdma_pkg.sv - shared IPIC type codes, arbiter state encoding and defaults
package tdma_pkg;

    localparam int TIMEOUT_CYCLES_DEFAULT = 1024;

    typedef enum logic [2:0] {
        BURST_RD  = 3'd0,
        BURST_WR  = 3'd1,
        SINGLE_RD = 3'd2,
        SINGLE_WR = 3'd3
    } ipic_type_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_ACK  = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_e;

    // Write types steer the address onto write_addr/write_length; every other
    // code is treated as a read.
    function automatic logic is_write_type(input logic [2:0] t);
        return (t == BURST_WR) || (t == SINGLE_WR);
    endfunction

endpackage

// File: rtl/rr_select.sv
// rtl/rr_select.sv - combinational round-robin pick starting at rr_ptr
// Ports: req (request vector), rr_ptr (search start), grant (chosen index),
// valid (any request present).
module rr_select #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [ID_W-1:0]    grant,
    output logic               valid
);

    int              idx;
    logic [ID_W-1:0] idx_l;

    // Walk offsets from the farthest to the nearest so the nearest requester
    // at or above rr_ptr (with wrap) is the last writer and wins.
    always_comb begin
        grant = rr_ptr;
        valid = 1'b0;
        idx   = 0;
        idx_l = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx   = (int'(rr_ptr) + i) % NUM_REQ;
            idx_l = ID_W'(idx);
            if (req[idx_l]) begin
                grant = idx_l;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tdma_ipic_arbiter.sv
// rtl/tdma_ipic_arbiter.sv - round-robin arbiter of NUM_REQ requesters onto one IPIC master
// Ports: clk/reset (sync, active-high); requester side req_start/req_type/
// req_addr/req_length in, req_ack/req_done/req_err/rd_data out; IPIC side
// ipic_start/ipic_type/read_addr/write_addr/write_length out, ipic_ack/
// ipic_done_wire/single_read_data in; status busy/grant_id/err_count.
module tdma_ipic_arbiter
    import tdma_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int C_LENGTH_WIDTH = 14,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
    localparam int ID_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_REQ-1:0]                req_start,
    input  logic [NUM_REQ*3-1:0]              req_type,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]     req_addr,
    input  logic [NUM_REQ*C_LENGTH_WIDTH-1:0] req_length,
    output logic [NUM_REQ-1:0]                req_ack,
    output logic [NUM_REQ-1:0]                req_done,
    output logic                              req_err,
    output logic [DATA_WIDTH-1:0]             rd_data,
    output logic                              ipic_start,
    output logic [2:0]                        ipic_type,
    output logic [ADDR_WIDTH-1:0]             read_addr,
    output logic [ADDR_WIDTH-1:0]             write_addr,
    output logic [C_LENGTH_WIDTH-1:0]         write_length,
    input  logic                              ipic_ack,
    input  logic                              ipic_done_wire,
    input  logic [DATA_WIDTH-1:0]             single_read_data,
    output logic                              busy,
    output logic [ID_W-1:0]                   grant_id,
    output logic [7:0]                        err_count
);

    localparam int              WD_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

    state_e                      state_q, state_d;
    logic [ID_W-1:0]             rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]             grant_q, grant_d;
    logic [WD_W-1:0]             wdog_q, wdog_d;
    logic                        ipic_start_q, ipic_start_d;
    logic [2:0]                  ipic_type_q, ipic_type_d;
    logic [ADDR_WIDTH-1:0]       read_addr_q, read_addr_d;
    logic [ADDR_WIDTH-1:0]       write_addr_q, write_addr_d;
    logic [C_LENGTH_WIDTH-1:0]   write_length_q, write_length_d;
    logic [NUM_REQ-1:0]          req_ack_q, req_ack_d;
    logic [NUM_REQ-1:0]          req_done_q, req_done_d;
    logic                        req_err_q, req_err_d;
    logic [DATA_WIDTH-1:0]       rd_data_q, rd_data_d;
    logic [7:0]                  err_count_q, err_count_d;

    logic [ID_W-1:0]             sel_grant;
    logic                        sel_valid;
    logic [2:0]                  sel_type;
    logic [ADDR_WIDTH-1:0]       sel_addr;
    logic [C_LENGTH_WIDTH-1:0]   sel_len;
    logic [ID_W-1:0]             rr_next;
    logic                        wdog_hit;
    logic                        timeout_fire;

    rr_select #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_select (
        .req    (req_start),
        .rr_ptr (rr_ptr_q),
        .grant  (sel_grant),
        .valid  (sel_valid)
    );

    assign sel_type = req_type[int'(sel_grant)*3 +: 3];
    assign sel_addr = req_addr[int'(sel_grant)*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_len  = req_length[int'(sel_grant)*C_LENGTH_WIDTH +: C_LENGTH_WIDTH];
    assign rr_next  = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
    assign wdog_hit = (wdog_q == WD_LIMIT);

    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        grant_d        = grant_q;
        wdog_d         = wdog_q;
        ipic_start_d   = ipic_start_q;
        ipic_type_d    = ipic_type_q;
        read_addr_d    = read_addr_q;
        write_addr_d   = write_addr_q;
        write_length_d = write_length_q;
        req_ack_d      = '0;
        req_done_d     = '0;
        req_err_d      = 1'b0;
        rd_data_d      = rd_data_q;
        err_count_d    = err_count_q;
        timeout_fire   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (sel_valid) begin
                    grant_d     = sel_grant;
                    ipic_type_d = sel_type;
                    if (is_write_type(sel_type)) begin
                        write_addr_d   = sel_addr;
                        write_length_d = sel_len;
                    end else begin
                        read_addr_d = sel_addr;
                    end
                    ipic_start_d = 1'b1;
                    wdog_d       = '0;
                    state_d      = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                // Handshake is checked before the watchdog so it wins a tie.
                if (ipic_ack) begin
                    req_ack_d[grant_q] = 1'b1;
                    ipic_start_d       = 1'b0;
                    wdog_d             = '0;
                    state_d            = ST_WAIT_DONE;
                end else if (wdog_hit) begin
                    timeout_fire = 1'b1;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (ipic_done_wire) begin
                    rd_data_d           = single_read_data;
                    req_done_d[grant_q] = 1'b1;
                    rr_ptr_d            = rr_next;
                    state_d             = ST_IDLE;
                end else if (wdog_hit) begin
                    timeout_fire = 1'b1;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (timeout_fire) begin
            ipic_start_d        = 1'b0;
            req_done_d[grant_q] = 1'b1;
            req_err_d           = 1'b1;
            if (err_count_q != 8'hFF) begin
                err_count_d = err_count_q + 8'd1;
            end
            rr_ptr_d = rr_next;
            state_d  = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            rr_ptr_q       <= '0;
            grant_q        <= '0;
            wdog_q         <= '0;
            ipic_start_q   <= 1'b0;
            ipic_type_q    <= '0;
            read_addr_q    <= '0;
            write_addr_q   <= '0;
            write_length_q <= '0;
            req_ack_q      <= '0;
            req_done_q     <= '0;
            req_err_q      <= 1'b0;
            rd_data_q      <= '0;
            err_count_q    <= '0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            grant_q        <= grant_d;
            wdog_q         <= wdog_d;
            ipic_start_q   <= ipic_start_d;
            ipic_type_q    <= ipic_type_d;
            read_addr_q    <= read_addr_d;
            write_addr_q   <= write_addr_d;
            write_length_q <= write_length_d;
            req_ack_q      <= req_ack_d;
            req_done_q     <= req_done_d;
            req_err_q      <= req_err_d;
            rd_data_q      <= rd_data_d;
            err_count_q    <= err_count_d;
        end
    end

    assign req_ack      = req_ack_q;
    assign req_done     = req_done_q;
    assign req_err      = req_err_q;
    assign rd_data      = rd_data_q;
    assign ipic_start   = ipic_start_q;
    assign ipic_type    = ipic_type_q;
    assign read_addr    = read_addr_q;
    assign write_addr   = write_addr_q;
    assign write_length = write_length_q;
    assign busy         = (state_q != ST_IDLE);
    assign grant_id     = grant_q;
    assign err_count    = err_count_q;

endmodule

// File: tb/tb_tdma_ipic_arbiter.sv
// tb/tb_tdma_ipic_arbiter.sv - self-checking bench for tdma_ipic_arbiter
module tb_tdma_ipic_arbiter;

    localparam int NR = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 14;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [NR-1:0]   req_start;
    logic [NR*3-1:0] req_type;
    logic [NR*AW-1:0] req_addr;
    logic [NR*LW-1:0] req_length;
    logic [NR-1:0]   req_ack;
    logic [NR-1:0]   req_done;
    logic            req_err;
    logic [DW-1:0]   rd_data;
    logic            ipic_start;
    logic [2:0]      ipic_type;
    logic [AW-1:0]   read_addr;
    logic [AW-1:0]   write_addr;
    logic [LW-1:0]   write_length;
    logic            ipic_ack;
    logic            ipic_done_wire;
    logic [DW-1:0]   single_read_data;
    logic            busy;
    logic [1:0]      grant_id;
    logic [7:0]      err_count;

    always #5 clk = ~clk;

    tdma_ipic_arbiter #(
        .NUM_REQ        (NR),
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .C_LENGTH_WIDTH (LW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .req_start        (req_start),
        .req_type         (req_type),
        .req_addr         (req_addr),
        .req_length       (req_length),
        .req_ack          (req_ack),
        .req_done         (req_done),
        .req_err          (req_err),
        .rd_data          (rd_data),
        .ipic_start       (ipic_start),
        .ipic_type        (ipic_type),
        .read_addr        (read_addr),
        .write_addr       (write_addr),
        .write_length     (write_length),
        .ipic_ack         (ipic_ack),
        .ipic_done_wire   (ipic_done_wire),
        .single_read_data (single_read_data),
        .busy             (busy),
        .grant_id         (grant_id),
        .err_count        (err_count)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [2:0]  typ;
        int          ack_wait;
        int          done_wait;
        bit          noise;
        logic [31:0] data;
        logic [1:0]  grant;
        bit          chk_addr;
        logic [31:0] raddr;
        logic [31:0] waddr;
        logic [13:0] wlen;
    } vec_t;

    // One full transaction: start, optional stray handshakes, ack, done.
    task automatic run_txn(input vec_t v, input logic [7:0] exp_errc, input int id);
        req_type  = {4{v.typ}};
        req_start = v.req;
        tick();
        chk($sformatf("v%0d_start", id), ipic_start, 1'b1);
        chk($sformatf("v%0d_grant", id), grant_id, v.grant);
        chk($sformatf("v%0d_busy", id), busy, 1'b1);
        chk($sformatf("v%0d_type", id), ipic_type, v.typ);
        if (v.chk_addr) begin
            chk($sformatf("v%0d_raddr", id), read_addr, v.raddr);
            chk($sformatf("v%0d_waddr", id), write_addr, v.waddr);
            chk($sformatf("v%0d_wlen", id), write_length, v.wlen);
        end
        for (int k = 0; k < v.ack_wait; k++) begin
            if (v.noise && k == 0) ipic_done_wire = 1'b1;
            tick();
            ipic_done_wire = 1'b0;
            if (v.noise && k == 0)
                chk($sformatf("v%0d_done_ignored", id), {req_done, ipic_start}, {4'b0000, 1'b1});
        end
        ipic_ack = 1'b1;
        tick();
        ipic_ack = 1'b0;
        chk($sformatf("v%0d_ack", id), req_ack, 4'b0001 << v.grant);
        chk($sformatf("v%0d_start_clr", id), ipic_start, 1'b0);
        req_start = '0;
        for (int k = 0; k < v.done_wait; k++) begin
            if (v.noise && k == 0) ipic_ack = 1'b1;
            tick();
            ipic_ack = 1'b0;
            if (k == 0) chk($sformatf("v%0d_ack_pulse", id), req_ack, 4'b0000);
        end
        single_read_data = v.data;
        ipic_done_wire   = 1'b1;
        tick();
        ipic_done_wire   = 1'b0;
        single_read_data = '0;
        chk($sformatf("v%0d_done", id), req_done, 4'b0001 << v.grant);
        chk($sformatf("v%0d_err", id), req_err, 1'b0);
        chk($sformatf("v%0d_rdata", id), rd_data, v.data);
        chk($sformatf("v%0d_idle", id), busy, 1'b0);
        chk($sformatf("v%0d_errcnt", id), err_count, exp_errc);
    endtask

    // Transaction left to expire, in WAIT_ACK (in_done=0) or WAIT_DONE.
    task automatic timeout_txn(input bit in_done, input logic [3:0] req, input logic [1:0] g,
                               input bit verbose, input int id);
        int cnt = 0;
        bit ack_seen = 0;
        bit start_low = 0;
        req_start = req;
        tick();
        if (in_done) begin
            ipic_ack = 1'b1;
            tick();
            ipic_ack = 1'b0;
        end
        while (busy && cnt < 20) begin
            if (!in_done && req_ack != 4'b0000) ack_seen = 1;
            if (!in_done && !ipic_start) start_low = 1;
            cnt++;
            tick();
        end
        req_start = '0;
        if (verbose) begin
            chk($sformatf("to%0d_cycles", id), cnt, 8);
            chk($sformatf("to%0d_done", id), req_done, 4'b0001 << g);
            chk($sformatf("to%0d_err", id), req_err, 1'b1);
            chk($sformatf("to%0d_start", id), ipic_start, 1'b0);
            if (!in_done) begin
                chk($sformatf("to%0d_no_ack", id), ack_seen, 1'b0);
                chk($sformatf("to%0d_start_held", id), start_low, 1'b0);
            end
        end
        tick();
    endtask

    vec_t vecs[7];

    initial begin
        // req, typ, ack_wait, done_wait, noise, data, grant, chk_addr, raddr, waddr, wlen
        vecs[0] = '{4'b0010, 3'd2, 2, 2, 1'b0, 32'hDEADBEEF, 2'd1, 1'b1, 32'h60000808, 32'h00000000, 14'd0};
        vecs[1] = '{4'b0100, 3'd1, 1, 3, 1'b1, 32'h12345678, 2'd2, 1'b1, 32'h60000808, 32'h10000020, 14'd16};
        vecs[2] = '{4'b1001, 3'd3, 3, 1, 1'b0, 32'hA5A5A5A5, 2'd3, 1'b1, 32'h60000808, 32'h30000400, 14'd32};
        vecs[3] = '{4'b1001, 3'd0, 1, 1, 1'b1, 32'h0BADF00D, 2'd0, 1'b1, 32'h00001000, 32'h30000400, 14'd32};
        vecs[4] = '{4'b1111, 3'd2, 0, 0, 1'b0, 32'hCAFEF00D, 2'd1, 1'b1, 32'h60000808, 32'h30000400, 14'd32};
        vecs[5] = '{4'b0011, 3'd1, 2, 2, 1'b0, 32'h00000001, 2'd0, 1'b1, 32'h60000808, 32'h00001000, 14'd4};
        // ack and done both arrive on the watchdog limit cycle
        vecs[6] = '{4'b0100, 3'd0, 7, 7, 1'b1, 32'hFFFF0000, 2'd2, 1'b1, 32'h10000020, 32'h00001000, 14'd4};

        reset            = 1'b1;
        req_start        = '0;
        req_type         = '0;
        req_addr         = {32'h30000400, 32'h10000020, 32'h60000808, 32'h00001000};
        req_length       = {14'd32, 14'd16, 14'd8, 14'd4};
        ipic_ack         = 1'b0;
        ipic_done_wire   = 1'b0;
        single_read_data = '0;
        tick();
        tick();
        chk("reset_addr", {read_addr, write_addr}, 64'd0);
        chk("reset_ctl", {ipic_start, ipic_type, write_length, req_ack, req_done, req_err,
                          busy, grant_id, err_count}, 64'd0);
        chk("reset_rdata", rd_data, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) run_txn(vecs[i], 8'd0, i);

        // Reset while waiting for done, with done arriving on the same edge.
        req_start = 4'b0010;
        tick();
        ipic_ack = 1'b1;
        tick();
        ipic_ack  = 1'b0;
        req_start = '0;
        tick();
        reset            = 1'b1;
        ipic_done_wire   = 1'b1;
        single_read_data = 32'h00000077;
        tick();
        reset            = 1'b0;
        ipic_done_wire   = 1'b0;
        single_read_data = '0;
        chk("rst_mid_addr", {read_addr, write_addr}, 64'd0);
        chk("rst_mid_ctl", {ipic_start, ipic_type, write_length, req_ack, req_err,
                            busy, grant_id, err_count}, 64'd0);
        chk("rst_mid_no_done", req_done, 4'b0000);
        chk("rst_mid_rdata", rd_data, 32'd0);

        // Contention from reset release: order 0,1,2,3 then 0 again.
        for (int i = 0; i < 5; i++) begin
            vec_t v;
            v = '{4'b1111, 3'd2, 1, 1, 1'b0, 32'h100 + 32'(i), 2'(i % 4), 1'b0, 32'd0, 32'd0, 14'd0};
            run_txn(v, 8'd0, 10 + i);
        end

        reset = 1'b1;
        tick();
        reset = 1'b0;
        timeout_txn(1'b0, 4'b0001, 2'd0, 1'b1, 1);
        chk("to1_errcnt", err_count, 8'd1);
        timeout_txn(1'b1, 4'b0001, 2'd0, 1'b1, 2);
        chk("to2_errcnt", err_count, 8'd2);
        for (int i = 3; i <= 255; i++) timeout_txn(1'(i % 2), 4'b1111, 2'd0, 1'b0, i);
        chk("to255_errcnt", err_count, 8'd255);
        timeout_txn(1'b0, 4'b1111, 2'd0, 1'b0, 256);
        chk("to256_errcnt_sat", err_count, 8'd255);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/tdma_ipic_arbiter.md
TDMA_IPIC_ARBITER -- requirements
Module: tdma_ipic_arbiter

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- NUM_REQ, 4, number of requesters.
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width.
- C_LENGTH_WIDTH, 14, burst length width.
- TIMEOUT_CYCLES, 1024, ack/done watchdog limit.

REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.

REQ-003 Requester-side ports:
- req_start  in  NUM_REQ  per-requester transaction request, held until its req_ack.
- req_type  in  NUM_REQ*3  per-requester IPIC type (BURST_RD=0, BURST_WR=1, SINGLE_RD=2, SINGLE_WR=3).
- req_addr  in  NUM_REQ*ADDR_WIDTH  per-requester address.
- req_length  in  NUM_REQ*C_LENGTH_WIDTH  per-requester write length.
- req_ack  out  NUM_REQ  one-cycle grant acknowledge.
- req_done  out  NUM_REQ  one-cycle completion pulse.
- req_err  out  1  qualifies req_done: 1 means timeout.
- rd_data  out  DATA_WIDTH  single-read data, valid with req_done.

REQ-004 IPIC-side ports:
- ipic_start  out  1  transaction start.
- ipic_type  out  3  transaction type.
- read_addr  out  ADDR_WIDTH  read address.
- write_addr  out  ADDR_WIDTH  write address.
- write_length  out  C_LENGTH_WIDTH  write length.
- ipic_ack  in  1  master accepted the transaction.
- ipic_done_wire  in  1  master finished the transaction.
- single_read_data  in  DATA_WIDTH  read result.

REQ-005 Status ports:
- busy  out  1  arbiter not in IDLE.
- grant_id  out  clog2(NUM_REQ)  current or last owner.
- err_count  out  8  saturating timeout count.

Function
REQ-006 States SHALL be IDLE, WAIT_ACK, WAIT_DONE.
REQ-007 IDLE, any req_start high:
- grant SHALL be the first requester with req_start high, searching from rr_ptr upward and wrapping modulo NUM_REQ.
- On the same edge: latch that requester's type, addr and length; drive ipic_type; drive read_addr for RD types and write_addr/write_length for WR types, leaving the others unchanged; set ipic_start=1; set busy=1; enter WAIT_ACK.
REQ-008 WAIT_ACK, ipic_ack=1: pulse req_ack[grant] for exactly one cycle, clear ipic_start, enter WAIT_DONE.
REQ-009 WAIT_DONE, ipic_done_wire=1:
- Capture single_read_data into rd_data and pulse req_done[grant] with req_err=0.
- Set rr_ptr=(grant+1) mod NUM_REQ and return to IDLE.
- IDLE SHALL last at least one cycle between grants.
REQ-010 Watchdog: a counter clears on entry to WAIT_ACK and WAIT_DONE and increments every cycle in those states. When it reaches TIMEOUT_CYCLES-1:
- Clear ipic_start and pulse req_done[grant] with req_err=1.
- Increment err_count, saturating at 255; advance rr_ptr; return to IDLE.
- No req_ack SHALL be issued if the timeout fires in WAIT_ACK.
REQ-011 If ipic_ack or ipic_done_wire coincides with the timeout cycle, the handshake event SHALL win and the timeout SHALL NOT fire.
REQ-012 ipic_ack seen in WAIT_DONE and ipic_done_wire seen in WAIT_ACK SHALL be ignored.
REQ-013 req_start changes on non-granted lines SHALL NOT affect the transaction in flight; pending requests are served in round-robin order.
REQ-014 At most one req_ack bit and one req_done bit SHALL be high in any cycle.

Reset
REQ-015 On reset:
- State SHALL go to IDLE, rr_ptr=0 and the watchdog counter=0.
- All outputs SHALL go to 0: ipic_start, ipic_type, read_addr, write_addr, write_length, req_ack, req_done, req_err, rd_data, busy, grant_id, err_count.
REQ-016 Reset asserted mid-transaction SHALL abandon the transaction without issuing req_done.

Structure
REQ-017 IPIC type codes, state encodings and the default TIMEOUT_CYCLES SHALL live in a shared package, tdma_pkg.
REQ-018 Round-robin selection SHALL be one combinational sub-module, rr_select: inputs req vector and rr_ptr; outputs grant index and valid.

Verification
REQ-019 Directed scenarios:
- Single request: req_start=4'b0010, SINGLE_RD, addr 0x60000808, ack at cycle 3, done at cycle 6 with data 0xDEADBEEF -> ipic_start high from cycle 1, req_ack[1] at cycle 4, req_done[1] with rd_data=0xDEADBEEF, req_err=0.
- Contention: all four requests held from reset release -> grant order 0,1,2,3, then 0 again if re-requested.
- Burst write: requester 2, BURST_WR, addr 0x10000020, length 16 -> write_addr=0x10000020 and write_length=16 at ipic_start; read_addr unchanged.
- Ack timeout: TIMEOUT_CYCLES=8, no ipic_ack -> ipic_start drops after 8 cycles; req_done pulse with req_err=1; err_count=1; no req_ack.
- Boundary: ipic_done_wire on the watchdog limit cycle -> normal completion with req_err=0; err_count unchanged. 256 timeouts -> err_count holds 255.
- Reset in WAIT_DONE -> all outputs 0 next cycle; no req_done; the next grant starts from requester 0.
